reg_dump_ctrl: RTL and testbench

REG_DUMP_CTRL -- requirements
Module: reg_dump_ctrl

---
 rtl/reg_dump_ctrl_pkg.sv | 26 ++
 rtl/reg_dump_ctrl_if.sv | 23 ++
 rtl/mux_32.sv | 11 +
 rtl/reg_dump_ctrl.sv | 139 +++++++++++++
 tb/tb_reg_dump_ctrl.sv | 330 +++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/reg_dump_ctrl_pkg.sv
// Shared types and constants for the register-dump controller: FSM state
// encoding, the probe/NOP instruction encodings and parameter defaults.
package reg_dump_ctrl_pkg;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_DRAIN   = 3'd1,
    ST_ISSUE   = 3'd2,
    ST_WAIT    = 3'd3,
    ST_PRESENT = 3'd4,
    ST_FINISH  = 3'd5
  } state_e;

  localparam logic [5:0]  OPC_ADDI = 6'b001000;
  localparam logic [31:0] NOP_INST = 32'h0000_0000;
  localparam logic [4:0]  LAST_IDX = 5'd31;

  localparam int unsigned PROBE_LAT_DEF = 3;
  localparam int unsigned DRAIN_CYC_DEF = 4;

  // addi $0, $rs, 0: reads rs through port A but writes nothing visible.
  function automatic logic [31:0] probe_inst(input logic [4:0] rs);
    return {OPC_ADDI, rs, 5'b00000, 16'h0000};
  endfunction

endpackage

// File: rtl/reg_dump_ctrl_if.sv
// Snapshot handshake between the dump controller (master) and its consumer.
interface reg_dump_ctrl_if;

  logic        dump_valid;
  logic        dump_ready;
  logic [4:0]  dump_idx;
  logic [31:0] dump_data;

  modport master (
    output dump_valid,
    output dump_idx,
    output dump_data,
    input  dump_ready
  );

  modport slave (
    input  dump_valid,
    input  dump_idx,
    input  dump_data,
    output dump_ready
  );

endinterface

// File: rtl/mux_32.sv
// 32-bit 2:1 instruction-word multiplexer.
module mux_32 (
  input  logic        sel_i,
  input  logic [31:0] in0_i,
  input  logic [31:0] in1_i,
  output logic [31:0] out_o
);

  assign out_o = sel_i ? in1_i : in0_i;

endmodule

// File: rtl/reg_dump_ctrl.sv
// Dumps all 32 pipeline registers by forcing probe instructions into the
// pipeline and presenting each captured port-A value over a valid/ready handshake.
module reg_dump_ctrl
  import reg_dump_ctrl_pkg::*;
#(
  parameter int unsigned PROBE_LAT = PROBE_LAT_DEF,
  parameter int unsigned DRAIN_CYC = DRAIN_CYC_DEF
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   start,
  input  logic [31:0]            core_inst,
  input  logic [31:0]            busA_probe,
  output logic [31:0]            inst_out,
  reg_dump_ctrl_if.master        dump,
  output logic                   busy,
  output logic                   done
);

  // ISSUE itself accounts for one latency cycle; WAIT covers the rest.
  localparam logic [3:0] LAT_LOAD   = 4'(PROBE_LAT - 1);
  localparam logic [3:0] DRAIN_LOAD = 4'(DRAIN_CYC);

  state_e      state_q, state_d;
  logic [4:0]  idx_q, idx_d;
  logic [3:0]  cnt_q, cnt_d;
  logic        capture;
  logic [4:0]  dump_idx_q;
  logic [31:0] dump_data_q;
  logic        inst_sel;
  logic [31:0] dump_inst;

  always_comb begin
    // NOTE: every signal driven here gets a default first, so no path through
    // the case statement can leave one unassigned and infer a latch.
    state_d = state_q;
    idx_d   = idx_q;
    cnt_d   = cnt_q;
    capture = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        if (start) begin
          idx_d = '0;
          if (DRAIN_LOAD != 4'd0) begin
            cnt_d   = DRAIN_LOAD;
            state_d = ST_DRAIN;
          end else begin
            state_d = ST_ISSUE;
          end
        end
      end

      ST_DRAIN: begin
        if (cnt_q <= 4'd1) begin
          cnt_d   = '0;
          state_d = ST_ISSUE;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end

      ST_ISSUE: begin
        if (LAT_LOAD == 4'd0) begin
          capture = 1'b1;
          state_d = ST_PRESENT;
        end else begin
          cnt_d   = LAT_LOAD;
          state_d = ST_WAIT;
        end
      end

      ST_WAIT: begin
        if (cnt_q <= 4'd1) begin
          cnt_d   = '0;
          capture = 1'b1;
          state_d = ST_PRESENT;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end

      ST_PRESENT: begin
        // Snapshot stays put until the consumer takes it; there is no timeout.
        if (dump.dump_ready) begin
          if (idx_q == LAST_IDX) begin
            idx_d   = '0;
            state_d = ST_FINISH;
          end else begin
            idx_d   = idx_q + 5'd1;
            state_d = ST_ISSUE;
          end
        end
      end

      ST_FINISH: state_d = ST_IDLE;

      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= ST_IDLE;
      idx_q       <= '0;
      cnt_q       <= '0;
      dump_idx_q  <= '0;
      dump_data_q <= '0;
    end else begin
      // NOTE: non-blocking assignments so every register samples the values
      // from before this edge, independent of statement order.
      state_q <= state_d;
      idx_q   <= idx_d;
      cnt_q   <= cnt_d;
      if (capture) begin
        dump_idx_q  <= idx_q;
        dump_data_q <= busA_probe;
      end
    end
  end

  assign dump.dump_valid = (state_q == ST_PRESENT);
  assign dump.dump_idx   = dump_idx_q;
  assign dump.dump_data  = dump_data_q;
  assign busy            = (state_q != ST_IDLE);
  assign done            = (state_q == ST_FINISH);

  // FINISH already hands the pipeline back to instruction memory.
  assign inst_sel  = busy && (state_q != ST_FINISH);
  assign dump_inst = (state_q == ST_DRAIN) ? NOP_INST : probe_inst(idx_q);

  mux_32 u_inst_mux (
    .sel_i (inst_sel),
    .in0_i (core_inst),
    .in1_i (dump_inst),
    .out_o (inst_out)
  );

endmodule

// File: tb/tb_reg_dump_ctrl.sv
// Self-checking bench for reg_dump_ctrl: a register-file/pipeline model feeds
// busA_probe and a scoreboard checks every dump against the expected sequence.
module tb_reg_dump_ctrl;

  localparam int PL         = 3;
  localparam int DC         = 4;
  localparam int CYC_BUDGET = 4000;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [31:0] core_inst;
  logic [31:0] busA_probe;
  logic [31:0] inst_out;
  logic        busy;
  logic        done;

  reg_dump_ctrl_if dif ();

  reg_dump_ctrl #(.PROBE_LAT(PL), .DRAIN_CYC(DC)) dut (
    .clk        (clk),
    .reset      (reset),
    .start      (start),
    .core_inst  (core_inst),
    .busA_probe (busA_probe),
    .inst_out   (inst_out),
    .dump       (dif),
    .busy       (busy),
    .done       (done)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  // Pipeline model: port A shows the register named by the rs field of the
  // instruction that entered the pipeline PL-1 cycles earlier.
  logic [31:0] rf [32];
  logic [4:0]  rs_pipe [PL-1];
  bit          noise_en = 1'b0;

  always @(posedge clk) begin
    rs_pipe[0] <= inst_out[25:21];
    for (int i = 1; i < PL - 1; i++) rs_pipe[i] <= rs_pipe[i-1];
  end

  always @(negedge clk) busA_probe = noise_en ? $urandom : rf[rs_pipe[PL-2]];

  // Scoreboard: records handshakes and done pulses; checks hold/gap rules live.
  bit          sb_en = 1'b0;
  int          cyc = 0;
  int          hs_idx[$];
  logic [31:0] hs_data[$];
  int          hs_cyc[$];
  int          done_cyc[$];
  bit          prev_valid, prev_stall, gap_armed;
  logic [4:0]  prev_idx;
  logic [31:0] prev_data;
  int          last_acc_cyc;

  always @(negedge clk) begin
    cyc++;
    if (!sb_en) begin
      hs_idx.delete(); hs_data.delete(); hs_cyc.delete(); done_cyc.delete();
      prev_valid = 1'b0; prev_stall = 1'b0; gap_armed = 1'b0;
    end else begin
      if (prev_stall) begin
        check("stall_valid", 32'(dif.dump_valid), 32'd1);
        check("stall_idx",   32'(dif.dump_idx),   32'(prev_idx));
        check("stall_data",  dif.dump_data,       prev_data);
      end
      if (dif.dump_valid && !prev_valid && gap_armed) begin
        check("valid_gap", 32'(cyc - last_acc_cyc), 32'(PL + 1));
        gap_armed = 1'b0;
      end
      if (dif.dump_valid) check("probe_inst", inst_out, {6'b001000, dif.dump_idx, 21'h0});
      if (!busy) check("idle_passthru", inst_out, core_inst);
      if (done) done_cyc.push_back(cyc);
      if (dif.dump_valid && dif.dump_ready) begin
        hs_idx.push_back(int'(dif.dump_idx));
        hs_data.push_back(dif.dump_data);
        hs_cyc.push_back(cyc);
        last_acc_cyc = cyc;
        gap_armed    = (dif.dump_idx != 5'd31);
      end
      prev_valid = dif.dump_valid;
      prev_stall = dif.dump_valid && !dif.dump_ready;
      prev_idx   = dif.dump_idx;
      prev_data  = dif.dump_data;
    end
  end

  bit rand_ready = 1'b0;

  task automatic step();
    @(posedge clk);
    #1;
    if (rand_ready) dif.dump_ready = ($urandom_range(3, 0) != 0);
  endtask

  task automatic sb_restart();
    sb_en = 1'b0;
    step();
    sb_en = 1'b1;
  endtask

  task automatic start_pulse();
    start = 1'b1;
    step();
    start = 1'b0;
  endtask

  task automatic wait_present(input logic [4:0] k, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < CYC_BUDGET; i++) begin
      if (dif.dump_valid && dif.dump_idx == k) begin
        ok = 1'b1;
        break;
      end
      step();
    end
    check($sformatf("reach_idx%0d", k), 32'(ok), 32'd1);
  endtask

  task automatic wait_done(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < CYC_BUDGET; i++) begin
      if (done) begin
        ok = 1'b1;
        break;
      end
      step();
    end
    check("done_seen", 32'(ok), 32'd1);
    step();
    check("post_done_inst",  inst_out,   core_inst);
    check("post_done_busy",  32'(busy),  32'd0);
    check("post_done_pulse", 32'(done),  32'd0);
  endtask

  task automatic check_dump(input string tag);
    check({tag, "_hs_count"}, 32'(hs_idx.size()), 32'd32);
    for (int k = 0; k < hs_idx.size() && k < 32; k++) begin
      check($sformatf("%s_idx%0d", tag, k),  32'(hs_idx[k]), 32'(k));
      check($sformatf("%s_data%0d", tag, k), hs_data[k],     rf[k]);
    end
    check({tag, "_done_count"}, 32'(done_cyc.size()), 32'd1);
    if (done_cyc.size() == 1 && hs_cyc.size() > 0)
      check({tag, "_done_timing"}, 32'(done_cyc[0] - hs_cyc[hs_cyc.size()-1]), 32'd1);
  endtask

  typedef struct {
    logic [31:0] core_inst;
    logic        dump_ready;
    logic [31:0] exp_inst;
    logic        exp_busy;
    logic        exp_valid;
    logic        exp_done;
  } vec_t;

  vec_t vecs[5];

  initial begin
    bit ok;

    reset = 1'b0;
    start = 1'b0;
    core_inst = 32'h2001_0005;
    dif.dump_ready = 1'b0;
    for (int k = 0; k < 32; k++) rf[k] = 32'(k) * 32'h0101;

    repeat (2) @(posedge clk);
    #1;
    check("rst_inst",  inst_out,              32'h2001_0005);
    check("rst_busy",  32'(busy),             32'd0);
    check("rst_valid", 32'(dif.dump_valid),   32'd0);
    check("rst_done",  32'(done),             32'd0);
    check("rst_idx",   32'(dif.dump_idx),     32'd0);
    check("rst_data",  dif.dump_data,         32'd0);
    reset = 1'b1;
    step();

    // IDLE passthrough, with stray dump_ready pulses that must be ignored.
    vecs[0] = '{32'h2001_0005, 1'b0, 32'h2001_0005, 1'b0, 1'b0, 1'b0};
    vecs[1] = '{32'hFFFF_FFFF, 1'b1, 32'hFFFF_FFFF, 1'b0, 1'b0, 1'b0};
    vecs[2] = '{32'h0000_0000, 1'b1, 32'h0000_0000, 1'b0, 1'b0, 1'b0};
    vecs[3] = '{32'h8C22_0004, 1'b0, 32'h8C22_0004, 1'b0, 1'b0, 1'b0};
    vecs[4] = '{32'h20A0_0000, 1'b1, 32'h20A0_0000, 1'b0, 1'b0, 1'b0};
    for (int v = 0; v < 5; v++) begin
      core_inst      = vecs[v].core_inst;
      dif.dump_ready = vecs[v].dump_ready;
      #1;
      check($sformatf("vec%0d_inst_comb", v), inst_out, vecs[v].exp_inst);
      step();
      check($sformatf("vec%0d_inst", v),  inst_out,                vecs[v].exp_inst);
      check($sformatf("vec%0d_busy", v),  32'(busy),               32'(vecs[v].exp_busy));
      check($sformatf("vec%0d_valid", v), 32'(dif.dump_valid),     32'(vecs[v].exp_valid));
      check($sformatf("vec%0d_done", v),  32'(done),               32'(vecs[v].exp_done));
    end

    // Full dump with ready tied high; drain length and idx 5 latency checked by hand.
    core_inst = 32'h2001_0005;
    dif.dump_ready = 1'b1;
    sb_restart();
    start_pulse();
    for (int i = 0; i < DC; i++) begin
      check($sformatf("drain%0d_nop", i),  inst_out,  32'h0000_0000);
      check($sformatf("drain%0d_busy", i), 32'(busy), 32'd1);
      step();
    end
    check("issue0_inst", inst_out, 32'h2000_0000);
    wait_present(5'd4, ok);
    step();
    check("idx5_issue_inst",  inst_out,            32'h20A0_0000);
    check("idx5_issue_valid", 32'(dif.dump_valid), 32'd0);
    for (int i = 1; i < PL; i++) begin
      step();
      check($sformatf("idx5_wait%0d_valid", i), 32'(dif.dump_valid), 32'd0);
    end
    step();
    check("idx5_valid", 32'(dif.dump_valid), 32'd1);
    check("idx5_idx",   32'(dif.dump_idx),   32'd5);
    check("idx5_data",  dif.dump_data,       rf[5]);
    wait_done(ok);
    check_dump("full");

    // Consumer stalls at idx 7 for 10 cycles while port A is noise.
    sb_restart();
    start_pulse();
    wait_present(5'd6, ok);
    step();
    dif.dump_ready = 1'b0;
    wait_present(5'd7, ok);
    noise_en = 1'b1;
    for (int i = 0; i < 10; i++) begin
      check($sformatf("stall%0d_valid", i), 32'(dif.dump_valid), 32'd1);
      check($sformatf("stall%0d_idx", i),   32'(dif.dump_idx),   32'd7);
      check($sformatf("stall%0d_data", i),  dif.dump_data,       rf[7]);
      step();
    end
    noise_en = 1'b0;
    dif.dump_ready = 1'b1;
    wait_done(ok);
    check_dump("stall");

    // start re-asserted mid-dump must not restart it.
    sb_restart();
    start_pulse();
    wait_present(5'd12, ok);
    start = 1'b1;
    repeat (3) step();
    start = 1'b0;
    wait_done(ok);
    check_dump("restart");

    // start held high for a whole dump: ignored while busy, restarts from IDLE.
    sb_restart();
    start = 1'b1;
    step();
    wait_done(ok);
    check_dump("held");
    step();
    check("held_restart_busy", 32'(busy), 32'd1);
    start = 1'b0;
    sb_restart();
    wait_done(ok);
    check_dump("held_second");

    // Reset while waiting on idx 20 abandons the dump at once.
    sb_restart();
    start_pulse();
    wait_present(5'd19, ok);
    step();
    check("idx20_issue_inst", inst_out, 32'h2280_0000);
    step();
    sb_en = 1'b0;
    core_inst = 32'h1234_5678;
    #2;
    reset = 1'b0;
    #1;
    check("midrst_inst",  inst_out,            32'h1234_5678);
    check("midrst_busy",  32'(busy),           32'd0);
    check("midrst_valid", 32'(dif.dump_valid), 32'd0);
    check("midrst_done",  32'(done),           32'd0);
    check("midrst_idx",   32'(dif.dump_idx),   32'd0);
    check("midrst_data",  dif.dump_data,       32'd0);
    @(posedge clk);
    #1;
    reset = 1'b1;
    start = 1'b1;
    sb_en = 1'b1;
    step();
    start = 1'b0;
    check("post_rst_start_busy", 32'(busy), 32'd1);
    wait_done(ok);
    check_dump("after_reset");

    // Randomised register contents, core instruction and consumer back-pressure.
    for (int r = 0; r < 3; r++) begin
      rf[0] = 32'h0;
      for (int k = 1; k < 32; k++) rf[k] = $urandom;
      core_inst  = $urandom;
      rand_ready = 1'b1;
      sb_restart();
      start_pulse();
      wait_done(ok);
      check_dump($sformatf("rand%0d", r));
    end
    rand_ready = 1'b0;

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
